// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter for the VGA pixel path.
// One synchronous-read pixel memory is shared between the display scan-out
// (absolute priority, raster order) and a valid/ready writer port. Display
// pixels come back at a fixed latency through a short tag pipeline.
module vga_fb_arbiter #(
  parameter int H_PIX  = 160,
  parameter int V_PIX  = 120,
  parameter int ADDR_W = 15,
  parameter int PIX_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              disp_req,
  output logic [PIX_W-1:0]  disp_data,
  output logic              disp_valid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic [PIX_W-1:0]  mem_rdata,
  input  logic              clr_err,
  output logic              wr_oor
);

  localparam int                FB_SIZE = H_PIX * V_PIX;
  localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_SIZE - 1);

  // Memory-port grant decided this cycle.
  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_READ,
    GNT_WRITE,
    GNT_DROP
  } gnt_t;

  logic              en_q;
  logic [ADDR_W-1:0] disp_ptr;
  logic [ADDR_W-1:0] ptr_next;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        rd_tag;
  logic              wr_fire;
  logic              wr_in_range;
  gnt_t              gnt;

  // The writer is held off until one edge after reset release, and on every
  // cycle the display claims the port.
  assign wr_ready    = en_q & ~disp_req;
  assign wr_fire     = wr_valid & wr_ready;
  assign wr_in_range = (wr_addr <= FB_LAST);

  // Enable flag: goes high on the first edge after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= 1'b0;
    end else begin
      en_q <= 1'b1;
    end
  end

  // Read address and next display pointer; a frame_start coinciding with a
  // request makes that request fetch pixel 0.
  always_comb begin
    rd_addr  = frame_start ? '0 : disp_ptr;
    ptr_next = disp_ptr;
    if (disp_req) begin
      ptr_next = (rd_addr == FB_LAST) ? '0 : rd_addr + ADDR_W'(1);
    end else if (frame_start) begin
      ptr_next = '0;
    end
  end

  // Arbitration: display first, then writer; out-of-range writes complete
  // the handshake but never reach the memory.
  always_comb begin
    gnt = GNT_IDLE;
    if (disp_req) begin
      gnt = GNT_READ;
    end else if (wr_fire) begin
      gnt = wr_in_range ? GNT_WRITE : GNT_DROP;
    end
  end

  // Raster-order display pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_ptr <= '0;
    end else begin
      disp_ptr <= ptr_next;
    end
  end

  // Registered memory port; address and data hold while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      case (gnt)
        GNT_READ: begin
          mem_addr <= rd_addr;
        end
        GNT_WRITE: begin
          mem_addr  <= wr_addr;
          mem_we    <= 1'b1;
          mem_wdata <= wr_data;
        end
        default: begin
        end
      endcase
    end
  end

  // Read-return tag pipeline: stage 0 marks the cycle the address is on the
  // port, stage 1 the cycle mem_rdata is valid, which is then captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_tag     <= '0;
      disp_valid <= 1'b0;
      disp_data  <= '0;
    end else begin
      rd_tag     <= {rd_tag[0], disp_req};
      disp_valid <= rd_tag[1];
      if (rd_tag[1]) begin
        disp_data <= mem_rdata;
      end
    end
  end

  // Sticky out-of-range flag; a new dropped write beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_oor <= 1'b0;
    end else if (gnt == GNT_DROP) begin
      wr_oor <= 1'b1;
    end else if (clr_err) begin
      wr_oor <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural synchronous-read
// frame-buffer memory attached to the memory port.
module tb_vga_fb_arbiter;

  localparam int H_PIX   = 160;
  localparam int V_PIX   = 120;
  localparam int ADDR_W  = 15;
  localparam int PIX_W   = 6;
  localparam int FB_SIZE = H_PIX * V_PIX;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              frame_start = 1'b0;
  logic              disp_req = 1'b0;
  logic              wr_valid = 1'b0;
  logic              clr_err = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [PIX_W-1:0]  wr_data = '0;
  logic [PIX_W-1:0]  disp_data;
  logic              disp_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [PIX_W-1:0]  mem_wdata;
  logic [PIX_W-1:0]  mem_rdata = '0;
  logic              wr_oor;

  logic [PIX_W-1:0]  fb_mem [0:(1<<ADDR_W)-1];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vga_fb_arbiter #(
    .H_PIX(H_PIX), .V_PIX(V_PIX), .ADDR_W(ADDR_W), .PIX_W(PIX_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .disp_req(disp_req),
    .disp_data(disp_data), .disp_valid(disp_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .clr_err(clr_err), .wr_oor(wr_oor)
  );

  // synchronous-read pixel memory
  always @(posedge clk) begin
    if (mem_we) fb_mem[mem_addr] <= mem_wdata;
    mem_rdata <= fb_mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_read();
    disp_req = 1'b1;
    cyc();
    disp_req = 1'b0;
    cyc();
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_disp_data"},  32'(disp_data), 0);
    check({pfx, "_disp_valid"}, 32'(disp_valid), 0);
    check({pfx, "_mem_addr"},   32'(mem_addr), 0);
    check({pfx, "_mem_we"},     32'(mem_we), 0);
    check({pfx, "_mem_wdata"},  32'(mem_wdata), 0);
    check({pfx, "_wr_oor"},     32'(wr_oor), 0);
    check({pfx, "_wr_ready"},   32'(wr_ready), 0);
  endtask

  initial begin
    int rd;
    int wc;
    bit is_rd;
    for (int i = 0; i < (1 << ADDR_W); i++) fb_mem[i] = '0;

    // power-on reset
    #23;
    check_all_zero("por");
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check("por_ready_first", 32'(wr_ready), 0);
    cyc();
    check("por_ready_second", 32'(wr_ready), 1);

    // fill: addr k <- k[5:0]
    wr_valid = 1'b1;
    for (int k = 0; k < FB_SIZE; k++) begin
      wr_addr = ADDR_W'(k);
      wr_data = PIX_W'(k);
      cyc();
      if (k == 0 || k == FB_SIZE - 1) begin
        check("fill_we",    32'(mem_we), 1);
        check("fill_addr",  32'(mem_addr), 32'(k));
        check("fill_wdata", 32'(mem_wdata), 32'(k % 64));
      end
    end
    wr_valid = 1'b0;
    cyc();
    check("fill_idle_we",   32'(mem_we), 0);
    check("fill_idle_addr", 32'(mem_addr), 32'(FB_SIZE - 1));

    // scan from frame_start, request every other cycle
    frame_start = 1'b1;
    disp_req    = 1'b1;
    cyc();
    frame_start = 1'b0;
    for (int i = 0; i < 130; i++) begin
      check("scan_addr", 32'(mem_addr), 32'(i));
      check("scan_rd_we", 32'(mem_we), 0);
      disp_req = 1'b0;
      cyc();
      check("scan_valid_early", 32'(disp_valid), 0);
      disp_req = (i < 129);
      cyc();
      check("scan_valid", 32'(disp_valid), 1);
      check("scan_data",  32'(disp_data), 32'(i % 64));
    end
    disp_req = 1'b0;
    cyc();
    check("scan_valid_pulse", 32'(disp_valid), 0);
    cyc();

    // contention: writer always valid, display every other cycle
    rd = 130;
    wc = 0;
    wr_valid = 1'b1;
    for (int j = 0; j < 10; j++) begin
      is_rd    = (j % 2 == 0);
      disp_req = is_rd;
      wr_addr  = ADDR_W'(6000 + wc);
      wr_data  = PIX_W'(wc + 7);
      #1 check("cont_ready", 32'(wr_ready), 32'(!is_rd));
      cyc();
      if (is_rd) begin
        check("cont_rd_we",   32'(mem_we), 0);
        check("cont_rd_addr", 32'(mem_addr), 32'(rd));
        rd++;
      end else begin
        check("cont_wr_we",    32'(mem_we), 1);
        check("cont_wr_addr",  32'(mem_addr), 32'(6000 + wc));
        check("cont_wr_wdata", 32'(mem_wdata), 32'((wc + 7) % 64));
        wc++;
      end
    end
    wr_valid = 1'b0;
    disp_req = 1'b0;
    cyc();
    cyc();
    cyc();

    // wrap: a full frame of requests without frame_start
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    for (int n = 0; n < FB_SIZE; n++) begin
      disp_req = 1'b1;
      cyc();
      if (n == FB_SIZE - 1) check("wrap_last_addr", 32'(mem_addr), 32'(FB_SIZE - 1));
      disp_req = 1'b0;
      cyc();
    end
    disp_req = 1'b1;
    cyc();
    check("wrap_to_zero", 32'(mem_addr), 0);
    disp_req = 1'b0;
    cyc();
    for (int n = 1; n < 500; n++) begin
      disp_req = 1'b1;
      cyc();
      if (n == 499) check("pre_fs_addr", 32'(mem_addr), 499);
      disp_req = 1'b0;
      cyc();
    end
    frame_start = 1'b1;
    disp_req    = 1'b1;
    cyc();
    check("fs_req_addr", 32'(mem_addr), 0);
    frame_start = 1'b0;
    disp_req    = 1'b0;
    cyc();
    disp_req = 1'b1;
    cyc();
    check("fs_next_addr", 32'(mem_addr), 1);
    disp_req = 1'b0;
    cyc();

    // frame_start mid-flight: in-flight read keeps its old address data
    disp_req = 1'b1;
    cyc();
    check("midfs_rd_addr", 32'(mem_addr), 2);
    disp_req    = 1'b0;
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    cyc();
    check("midfs_valid", 32'(disp_valid), 1);
    check("midfs_data",  32'(disp_data), 2);
    disp_req = 1'b1;
    cyc();
    check("midfs_next_addr", 32'(mem_addr), 0);
    disp_req = 1'b0;
    cyc();
    cyc();

    // out-of-range writes and sticky error flag
    wr_valid = 1'b1;
    wr_addr  = ADDR_W'(FB_SIZE);
    wr_data  = 6'h3F;
    #1 check("oor_ready", 32'(wr_ready), 1);
    cyc();
    check("oor_we",  32'(mem_we), 0);
    check("oor_set", 32'(wr_oor), 1);
    wr_valid = 1'b0;
    cyc();
    check("oor_sticky", 32'(wr_oor), 1);
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    check("oor_clear", 32'(wr_oor), 0);
    clr_err  = 1'b1;
    wr_valid = 1'b1;
    wr_addr  = ADDR_W'(FB_SIZE + 1);
    cyc();
    clr_err  = 1'b0;
    wr_valid = 1'b0;
    check("oor_set_wins", 32'(wr_oor), 1);
    check("oor_we2",      32'(mem_we), 0);
    clr_err = 1'b1;
    cyc();
    clr_err  = 1'b0;
    wr_valid = 1'b1;
    wr_addr  = ADDR_W'(100);
    wr_data  = 6'h15;
    cyc();
    wr_valid = 1'b0;
    check("inrange_no_oor", 32'(wr_oor), 0);
    check("inrange_we",     32'(mem_we), 1);

    // read-after-write on consecutive edges
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    for (int n = 0; n < 37; n++) issue_read();
    wr_valid = 1'b1;
    wr_addr  = ADDR_W'(37);
    wr_data  = 6'h2A;
    cyc();
    check("raw_we", 32'(mem_we), 1);
    wr_valid = 1'b0;
    disp_req = 1'b1;
    cyc();
    check("raw_rd_addr", 32'(mem_addr), 37);
    check("raw_rd_we",   32'(mem_we), 0);
    disp_req = 1'b0;
    cyc();
    cyc();
    check("raw_valid", 32'(disp_valid), 1);
    check("raw_data",  32'(disp_data), 32'(6'h2A));

    // async reset with reads in flight (ptr is 38, data 0x26)
    disp_req = 1'b1;
    cyc();
    disp_req = 1'b0;
    cyc();
    disp_req = 1'b1;
    cyc();
    disp_req = 1'b0;
    check("pre_rst_data", 32'(disp_data), 32'(38));
    rst_n = 1'b0;
    #1 check_all_zero("arst");
    #2 rst_n = 1'b1;
    #1 check("arst_ready_first", 32'(wr_ready), 0);
    cyc();
    check("arst_ready_second", 32'(wr_ready), 1);
    check("arst_no_valid0", 32'(disp_valid), 0);
    for (int n = 1; n < 4; n++) begin
      cyc();
      check("arst_no_valid", 32'(disp_valid), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
